// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcodes/functs,
// ALU operation codes and the instruction decode helper.
package mips_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_ADDI = 3'd1,
    CLS_LW   = 3'd2,
    CLS_SW   = 3'd3,
    CLS_BEQ  = 3'd4,
    CLS_J    = 3'd5
  } instr_cls_e;

  // 0 is reserved for "no ALU operation in use".
  typedef enum logic [2:0] {
    ALU_NOP = 3'd0,
    ALU_ADD = 3'd1,
    ALU_SUB = 3'd2,
    ALU_AND = 3'd3,
    ALU_OR  = 3'd4,
    ALU_SLT = 3'd5
  } alu_op_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef struct packed {
    logic       legal;
    instr_cls_e cls;
    alu_op_e    alu;
  } dec_t;

  function automatic dec_t mips_decode(input logic [5:0] op, input logic [5:0] fn);
    dec_t d;
    d.legal = 1'b1;
    d.cls   = CLS_J;
    d.alu   = ALU_NOP;
    case (op)
      OP_R: begin
        d.cls = CLS_R;
        case (fn)
          FN_ADD:  d.alu = ALU_ADD;
          FN_SUB:  d.alu = ALU_SUB;
          FN_AND:  d.alu = ALU_AND;
          FN_OR:   d.alu = ALU_OR;
          FN_SLT:  d.alu = ALU_SLT;
          default: d.legal = 1'b0;
        endcase
      end
      OP_ADDI: begin d.cls = CLS_ADDI; d.alu = ALU_ADD; end
      OP_LW:   begin d.cls = CLS_LW;   d.alu = ALU_ADD; end
      OP_SW:   begin d.cls = CLS_SW;   d.alu = ALU_ADD; end
      OP_BEQ:  begin d.cls = CLS_BEQ;  d.alu = ALU_SUB; end
      OP_J:    begin d.cls = CLS_J;    d.alu = ALU_NOP; end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle timer for memory handshakes: clears on request, counts while enabled,
// flags expiry on the MEM_TIMEOUT-th counted cycle. MEM_TIMEOUT=0 never expires.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_cnt_en,
  output logic o_expire
);

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst)          r_cnt <= '0;
    else if (i_clr)    r_cnt <= '0;
    else if (i_cnt_en) r_cnt <= r_cnt + TW'(1);
  end

  generate
    if (MEM_TIMEOUT > 0) begin : g_timeout
      assign o_expire = i_cnt_en && (r_cnt == TW'(MEM_TIMEOUT - 1));
    end else begin : g_no_timeout
      assign o_expire = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and issues one pc_en
// per retired instruction. Optional perf counters under MIPS_CTRL_PERF_EN.
module mips_ctrl_fsm
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zeroflag,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        ir_load,
  output logic        pc_en,
  output logic        branchFlag,
  output logic        jmpFlag,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_we,
  output logic [2:0]  alu_op,
`ifdef MIPS_CTRL_PERF_EN
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt,
`endif
  output logic        fault
);

  state_e     r_state, w_next;
  instr_cls_e r_cls;
  alu_op_e    r_alu;
  dec_t       w_dec;
  logic       w_tmr_clr, w_tmr_en, w_expire;

  assign w_dec = mips_decode(opcode, funct);

  // Decoded class/ALU op are latched once so later states don't depend on IR timing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_FETCH;
      r_cls   <= CLS_J;
      r_alu   <= ALU_NOP;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) begin
        r_cls <= w_dec.cls;
        r_alu <= w_dec.alu;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_tmr_en   = 1'b0;
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    pc_en      = 1'b0;
    branchFlag = 1'b0;
    jmpFlag    = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    reg_we     = 1'b0;
    alu_op     = ALU_NOP;
    fault      = 1'b0;
    case (r_state)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ack;
        if (imem_ack) begin
          w_next = ST_DECODE;
        end else begin
          w_tmr_en = 1'b1;
          if (w_expire) w_next = ST_FAULT;
        end
      end
      ST_DECODE: w_next = w_dec.legal ? ST_EXEC : ST_FAULT;
      ST_EXEC: begin
        alu_op = r_alu;
        case (r_cls)
          CLS_BEQ, CLS_J: begin pc_en = 1'b1; w_next = ST_FETCH; end
          CLS_LW, CLS_SW: w_next = ST_MEM;
          default:        w_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        alu_op   = r_alu;
        dmem_req = 1'b1;
        dmem_we  = (r_cls == CLS_SW);
        if (dmem_ack) begin
          if (r_cls == CLS_SW) begin
            pc_en  = 1'b1;
            w_next = ST_FETCH;
          end else begin
            w_next = ST_WB;
          end
        end else begin
          w_tmr_en = 1'b1;
          if (w_expire) w_next = ST_FAULT;
        end
      end
      ST_WB: begin
        alu_op = r_alu;
        reg_we = 1'b1;
        pc_en  = 1'b1;
        w_next = ST_FETCH;
      end
      ST_FAULT: fault = 1'b1;
      default:  w_next = ST_FAULT;
    endcase
    branchFlag = pc_en & (r_cls == CLS_BEQ) & zeroflag;
    jmpFlag    = pc_en & (r_cls == CLS_J);
    // Reset cycle: nothing leaks out, including a pc_en for an abandoned instruction.
    if (!rst) begin
      imem_req   = 1'b0;
      ir_load    = 1'b0;
      pc_en      = 1'b0;
      branchFlag = 1'b0;
      jmpFlag    = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      reg_we     = 1'b0;
      alu_op     = ALU_NOP;
      fault      = 1'b0;
    end
  end

  assign w_tmr_clr = (w_next != r_state);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_tmr_clr),
    .i_cnt_en (w_tmr_en),
    .o_expire (w_expire)
  );

`ifdef MIPS_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else if (r_state != ST_FAULT) begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (pc_en) instr_cnt <= instr_cnt + 32'd1;
    end
  end
`else
  // Perf counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Directed-vector bench for mips_ctrl_fsm (MEM_TIMEOUT=16); perf counters checked when
// MIPS_CTRL_PERF_EN is defined.
module tb_mips_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode, funct;
  logic        zeroflag, imem_ack, dmem_ack;
  logic        imem_req, ir_load, pc_en, branchFlag, jmpFlag;
  logic        dmem_req, dmem_we, reg_we, fault;
  logic [2:0]  alu_op;
`ifdef MIPS_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mips_ctrl_fsm #(.MEM_TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct      (funct),
    .zeroflag   (zeroflag),
    .imem_ack   (imem_ack),
    .dmem_ack   (dmem_ack),
    .imem_req   (imem_req),
    .ir_load    (ir_load),
    .pc_en      (pc_en),
    .branchFlag (branchFlag),
    .jmpFlag    (jmpFlag),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .reg_we     (reg_we),
    .alu_op     (alu_op),
`ifdef MIPS_CTRL_PERF_EN
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt),
`endif
    .fault      (fault)
  );

  localparam logic [2:0] A_NOP = 3'd0, A_ADD = 3'd1, A_SUB = 3'd2,
                         A_AND = 3'd3, A_OR = 3'd4, A_SLT = 3'd5;

  typedef struct {
    string      nm;
    logic [5:0] op;
    logic [5:0] fn;
    logic       zf;
    int         iw;    // imem wait cycles before ack
    int         dw;    // dmem wait cycles before ack
    int         pc;    // expected cycle of pc_en (1 = first FETCH cycle)
    logic       br, jm, rwe, we;
    logic [2:0] alu;
    int         dreq;  // expected cycles with dmem_req high
  } vec_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1;
    #1;
    chk("rst.imem_req", 32'(imem_req), 0);
    chk("rst.fault", 32'(fault), 0);
    chk("rst.pc_en", 32'(pc_en), 0);
    cyc();
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int   pc_cyc = 0, npc = 0, mcnt = 0, dreq = 0;
    logic br = 0, jm = 0, rwe = 0, we = 0;
    logic [2:0] alu = 0;
    opcode = v.op; funct = v.fn; zeroflag = v.zf;
    for (int c = 1; c <= 24 && npc == 0; c++) begin
      imem_ack = (c > v.iw);
      dmem_ack = 1'b0;
      #1;
      if (dmem_req) begin
        mcnt++; dreq++;
        if (dmem_we) we = 1'b1;
        dmem_ack = (mcnt > v.dw);
      end
      #1;
      if (pc_en) begin
        npc++; pc_cyc = c;
        br = branchFlag; jm = jmpFlag; rwe = reg_we; alu = alu_op;
      end
      cyc();
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    chk({v.nm, ".pc_cycle"}, pc_cyc, v.pc);
    chk({v.nm, ".branch"}, 32'(br), 32'(v.br));
    chk({v.nm, ".jmp"}, 32'(jm), 32'(v.jm));
    chk({v.nm, ".reg_we"}, 32'(rwe), 32'(v.rwe));
    chk({v.nm, ".dmem_we"}, 32'(we), 32'(v.we));
    chk({v.nm, ".alu_op"}, 32'(alu), 32'(v.alu));
    chk({v.nm, ".dmem_req_cycles"}, dreq, v.dreq);
  endtask

  vec_t vecs[11];

  initial begin
    rst = 1'b0; opcode = '0; funct = '0; zeroflag = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    vecs[0]  = '{"add",      6'h00, 6'h20, 1'b0, 0, 0, 4, 1'b0, 1'b0, 1'b1, 1'b0, A_ADD, 0};
    vecs[1]  = '{"beq_t",    6'h04, 6'h00, 1'b1, 0, 0, 3, 1'b1, 1'b0, 1'b0, 1'b0, A_SUB, 0};
    vecs[2]  = '{"beq_nt",   6'h04, 6'h00, 1'b0, 0, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0, A_SUB, 0};
    vecs[3]  = '{"j",        6'h02, 6'h00, 1'b1, 0, 0, 3, 1'b0, 1'b1, 1'b0, 1'b0, A_NOP, 0};
    vecs[4]  = '{"lw_wait3", 6'h23, 6'h00, 1'b0, 0, 3, 8, 1'b0, 1'b0, 1'b1, 1'b0, A_ADD, 4};
    vecs[5]  = '{"sw",       6'h2B, 6'h00, 1'b0, 0, 0, 4, 1'b0, 1'b0, 1'b0, 1'b1, A_ADD, 1};
    vecs[6]  = '{"addi_iw2", 6'h08, 6'h00, 1'b0, 2, 0, 6, 1'b0, 1'b0, 1'b1, 1'b0, A_ADD, 0};
    vecs[7]  = '{"sub",      6'h00, 6'h22, 1'b0, 0, 0, 4, 1'b0, 1'b0, 1'b1, 1'b0, A_SUB, 0};
    vecs[8]  = '{"and",      6'h00, 6'h24, 1'b0, 0, 0, 4, 1'b0, 1'b0, 1'b1, 1'b0, A_AND, 0};
    vecs[9]  = '{"or",       6'h00, 6'h25, 1'b0, 0, 0, 4, 1'b0, 1'b0, 1'b1, 1'b0, A_OR,  0};
    vecs[10] = '{"slt_sw2",  6'h00, 6'h2A, 1'b0, 1, 0, 5, 1'b0, 1'b0, 1'b1, 1'b0, A_SLT, 0};

    do_reset();
    #1;
    chk("post_rst.imem_req", 32'(imem_req), 1);
    chk("post_rst.fault", 32'(fault), 0);
    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // ack arrives on the cycle the timer would expire: normal transition wins
    opcode = 6'h02; imem_ack = 1'b0;
    for (int c = 1; c <= 15; c++) cyc();
    imem_ack = 1'b1;
    #1;
    chk("late_ack.ir_load", 32'(ir_load), 1);
    cyc();
    chk("late_ack.fault", 32'(fault), 0);
    chk("late_ack.decode_imem_req", 32'(imem_req), 0);
    cyc();
    chk("late_ack.j_pc_en", 32'(pc_en), 1);
    chk("late_ack.jmp", 32'(jmpFlag), 1);
    cyc();

    // fetch timeout: 16 unanswered cycles then FAULT
    imem_ack = 1'b0;
    for (int c = 1; c <= 15; c++) cyc();
    chk("tmo.cycle16_fault", 32'(fault), 0);
    cyc();
    chk("tmo.cycle17_fault", 32'(fault), 1);
    chk("tmo.imem_req", 32'(imem_req), 0);
    imem_ack = 1'b1; dmem_ack = 1'b1;
    cyc(); cyc(); cyc();
    chk("tmo.sticky_fault", 32'(fault), 1);
    chk("tmo.sticky_pc_en", 32'(pc_en), 0);
    do_reset();
    #1;
    chk("tmo.cleared_fault", 32'(fault), 0);
    chk("tmo.cleared_imem_req", 32'(imem_req), 1);

    // illegal opcode
    opcode = 6'h3F; funct = 6'h20; imem_ack = 1'b1;
    cyc();
    chk("ill_op.decode_fault", 32'(fault), 0);
    cyc();
    chk("ill_op.fault", 32'(fault), 1);
    chk("ill_op.imem_req", 32'(imem_req), 0);
    do_reset();

    // illegal R-type funct
    opcode = 6'h00; funct = 6'h3F; imem_ack = 1'b1;
    cyc(); cyc();
    chk("ill_fn.fault", 32'(fault), 1);
    do_reset();

    // reset while LW is waiting in MEM
    opcode = 6'h23; funct = 6'h00; imem_ack = 1'b1;
    cyc(); cyc(); cyc();
    imem_ack = 1'b0;
    chk("rst_mem.dmem_req", 32'(dmem_req), 1);
    cyc();
    rst = 1'b0; dmem_ack = 1'b1;
    #1;
    chk("rst_mem.pc_en", 32'(pc_en), 0);
    chk("rst_mem.dmem_req_in_rst", 32'(dmem_req), 0);
    chk("rst_mem.reg_we", 32'(reg_we), 0);
    cyc();
    rst = 1'b1; dmem_ack = 1'b0;
    #1;
    chk("rst_mem.fetch_imem_req", 32'(imem_req), 1);
    chk("rst_mem.post_pc_en", 32'(pc_en), 0);
    chk("rst_mem.post_dmem_req", 32'(dmem_req), 0);

`ifdef MIPS_CTRL_PERF_EN
    do_reset();
    for (int i = 0; i < 10; i++) run_vec(vecs[3]);
    chk("perf.instr_cnt", instr_cnt, 32'd10);
    chk("perf.cycle_cnt", cycle_cnt, 32'd30);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
